// File: rtl/capp_pkg.sv
// Shared types and helpers for the comparand/mask line sequencer.
package capp_pkg;

  localparam logic MODE_WORD   = 1'b0;
  localparam logic MODE_SERIAL = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } cseq_state_t;

  // Differential pair for one bit: [0] asserts on a stored 0 mismatch, [1] on a stored 1.
  function automatic logic [1:0] line_pair(input logic cmp, input logic en);
    return {~cmp & en, cmp & en};
  endfunction

endpackage

// File: rtl/capp_next_bit.sv
// Finds the lowest set mask bit at or above a start index; start may equal WIDTH (none found).
module capp_next_bit #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask_i,
  input  logic [IDX_W:0]   start_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  localparam int START_W = IDX_W + 1;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Scan downwards so the last hit is the lowest qualifying bit.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_i[i] && (START_W'(i) >= start_i)) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/compare_sequencer.sv
// Latches a comparand/mask command and drives differential mismatch lines through
// timed settle/sample windows, either as one word search or bit-serially.
//
// state  | meaning
// IDLE   | cmd_ready high, lines off, waiting for a command
// DRIVE  | lines driven, settle down-counter running
// SAMPLE | lines still driven, sample_strobe high for this one cycle
// DONE   | lines off, done pulse, returns to IDLE
module compare_sequencer
  import capp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2,
  parameter int IDX_W  = $clog2(WIDTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_mode,
  input  logic [WIDTH-1:0]   cmd_comparand,
  input  logic [WIDTH-1:0]   cmd_mask,
  input  logic               abort,
  output logic [2*WIDTH-1:0] mismatch_lines,
  output logic               sample_strobe,
  output logic [IDX_W-1:0]   bit_index,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  cseq_state_t      state_q;
  logic             mode_q;
  logic [WIDTH-1:0] cmp_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] en_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             strobe_q;
  logic             done_q;

  logic [IDX_W-1:0] first_idx;
  logic             first_found;
  logic [IDX_W-1:0] next_idx;
  logic             next_found;
  logic [IDX_W:0]   next_start;

  assign next_start = (IDX_W+1)'(bit_idx_q) + (IDX_W+1)'(1);

  capp_next_bit #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_first (
    .mask_i  (cmd_mask),
    .start_i ('0),
    .idx_o   (first_idx),
    .found_o (first_found)
  );

  capp_next_bit #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_next (
    .mask_i  (mask_q),
    .start_i (next_start),
    .idx_o   (next_idx),
    .found_o (next_found)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      mode_q    <= MODE_WORD;
      cmp_q     <= '0;
      mask_q    <= '0;
      en_q      <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort && (state_q != IDLE)) begin
      state_q   <= IDLE;
      en_q      <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          strobe_q <= 1'b0;
          done_q   <= 1'b0;
          if (cmd_valid) begin
            cmp_q   <= cmd_comparand;
            mask_q  <= cmd_mask;
            mode_q  <= cmd_mode;
            cnt_q   <= CNT_LOAD;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (!first_found) begin
              state_q   <= DONE;
              en_q      <= '0;
              bit_idx_q <= '0;
              done_q    <= 1'b1;
            end else if (cmd_mode == MODE_WORD) begin
              state_q   <= DRIVE;
              en_q      <= cmd_mask;
              bit_idx_q <= '0;
            end else begin
              state_q   <= DRIVE;
              en_q      <= WIDTH'(1) << first_idx;
              bit_idx_q <= first_idx;
            end
          end
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            state_q  <= SAMPLE;
            strobe_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        SAMPLE: begin
          strobe_q <= 1'b0;
          if ((mode_q == MODE_WORD) || !next_found) begin
            state_q <= DONE;
            en_q    <= '0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= DRIVE;
            en_q      <= WIDTH'(1) << next_idx;
            bit_idx_q <= next_idx;
            cnt_q     <= CNT_LOAD;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          done_q    <= 1'b0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          bit_idx_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          en_q    <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_line
    assign mismatch_lines[2*g +: 2] = line_pair(cmp_q[g], en_q[g]);
  end

  assign cmd_ready     = ready_q;
  assign busy          = busy_q;
  assign sample_strobe = strobe_q;
  assign done          = done_q;
  assign bit_index     = bit_idx_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Directed bench for compare_sequencer (WIDTH=32, SETTLE=2) with hand-computed per-cycle expectations.
module tb_compare_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_mode = 1'b0;
  logic [31:0] cmd_comparand = '0;
  logic [31:0] cmd_mask = '0;
  logic        abort = 1'b0;
  logic        cmd_ready;
  logic [63:0] mismatch_lines;
  logic        sample_strobe;
  logic [4:0]  bit_index;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  compare_sequencer #(.WIDTH(32), .SETTLE(2)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_mode       (cmd_mode),
    .cmd_comparand  (cmd_comparand),
    .cmd_mask       (cmd_mask),
    .abort          (abort),
    .mismatch_lines (mismatch_lines),
    .sample_strobe  (sample_strobe),
    .bit_index      (bit_index),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Advance one cycle, then check every output; idx < 0 skips bit_index.
  task automatic step(input string tag, input logic [63:0] lines, input logic strobe,
                      input logic dn, input logic rdy, input int idx);
    tick();
    chk({tag, ".lines"},  mismatch_lines, lines);
    chk({tag, ".strobe"}, 64'(sample_strobe), 64'(strobe));
    chk({tag, ".done"},   64'(done), 64'(dn));
    chk({tag, ".ready"},  64'(cmd_ready), 64'(rdy));
    chk({tag, ".busy"},   64'(busy), 64'(!rdy));
    if (idx >= 0) chk({tag, ".idx"}, 64'(bit_index), 64'(idx));
  endtask

  task automatic issue(input logic mode, input logic [31:0] cmp, input logic [31:0] mask);
    cmd_mode      = mode;
    cmd_comparand = cmp;
    cmd_mask      = mask;
    cmd_valid     = 1'b1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst.lines",  mismatch_lines, 64'h0);
    chk("rst.ready",  64'(cmd_ready), 64'h1);
    chk("rst.busy",   64'(busy), 64'h0);
    chk("rst.strobe", 64'(sample_strobe), 64'h0);
    chk("rst.done",   64'(done), 64'h0);
    chk("rst.idx",    64'(bit_index), 64'h0);
    RST = 1'b0;
    tick();

    // 1: WORD search over the upper half
    issue(1'b0, 32'hA5A5_0000, 32'hFFFF_0000);
    step("w1c1", 64'h66996699_00000000, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    step("w1c2", 64'h66996699_00000000, 0, 0, 0, 0);
    step("w1c3", 64'h66996699_00000000, 1, 0, 0, 0);
    step("w1c4", 64'h0, 0, 1, 0, 0);
    step("w1c5", 64'h0, 0, 0, 1, 0);

    // 2: SERIAL over bits 0, 2, 4
    issue(1'b1, 32'h0000_0004, 32'h0000_0015);
    step("s2c1", 64'h2, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    step("s2c2",  64'h2,   0, 0, 0, 0);
    step("s2c3",  64'h2,   1, 0, 0, 0);
    step("s2c4",  64'h10,  0, 0, 0, 2);
    step("s2c5",  64'h10,  0, 0, 0, 2);
    step("s2c6",  64'h10,  1, 0, 0, 2);
    step("s2c7",  64'h200, 0, 0, 0, 4);
    step("s2c8",  64'h200, 0, 0, 0, 4);
    step("s2c9",  64'h200, 1, 0, 0, 4);
    step("s2c10", 64'h0,   0, 1, 0, -1);
    step("s2c11", 64'h0,   0, 0, 1, -1);

    // 3: empty mask goes straight to DONE in both modes
    issue(1'b0, 32'hFFFF_FFFF, 32'h0);
    step("m3w1", 64'h0, 0, 1, 0, 0);
    cmd_valid = 1'b0;
    step("m3w2", 64'h0, 0, 0, 1, 0);
    issue(1'b1, 32'h1234_5678, 32'h0);
    step("m3s1", 64'h0, 0, 1, 0, 0);
    cmd_valid = 1'b0;
    step("m3s2", 64'h0, 0, 0, 1, 0);

    // 4: only the top bit, comparand bit 0 -> line 63
    issue(1'b1, 32'h0, 32'h8000_0000);
    step("t4c1", 64'h80000000_00000000, 0, 0, 0, 31);
    cmd_valid = 1'b0;
    step("t4c2", 64'h80000000_00000000, 0, 0, 0, 31);
    step("t4c3", 64'h80000000_00000000, 1, 0, 0, 31);
    step("t4c4", 64'h0, 0, 1, 0, -1);
    step("t4c5", 64'h0, 0, 0, 1, -1);

    // 5: abort in the second SERIAL window, then a clean WORD command
    issue(1'b1, 32'h0000_0004, 32'h0000_0015);
    step("a5c1", 64'h2, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    step("a5c2", 64'h2,  0, 0, 0, 0);
    step("a5c3", 64'h2,  1, 0, 0, 0);
    step("a5c4", 64'h10, 0, 0, 0, 2);
    abort = 1'b1;
    step("a5ab", 64'h0, 0, 0, 1, -1);
    abort = 1'b0;
    step("a5id", 64'h0, 0, 0, 1, -1);
    issue(1'b0, 32'h0000_00FF, 32'h0000_000F);
    step("a5w1", 64'h55, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    step("a5w2", 64'h55, 0, 0, 0, 0);
    step("a5w3", 64'h55, 1, 0, 0, 0);
    step("a5w4", 64'h0,  0, 1, 0, 0);
    step("a5w5", 64'h0,  0, 0, 1, 0);

    // abort together with cmd_valid in IDLE still accepts
    issue(1'b0, 32'h1, 32'h1);
    abort = 1'b1;
    step("ai1", 64'h1, 0, 0, 0, 0);
    abort = 1'b0;
    cmd_valid = 1'b0;
    step("ai2", 64'h1, 0, 0, 0, 0);
    step("ai3", 64'h1, 1, 0, 0, 0);
    step("ai4", 64'h0, 0, 1, 0, 0);
    step("ai5", 64'h0, 0, 0, 1, 0);

    // 6: held cmd_valid ignored while busy, RST in SAMPLE, then held cmd accepted
    issue(1'b0, 32'h1, 32'h1);
    step("r6c1", 64'h1, 0, 0, 0, 0);
    cmd_comparand = 32'h3;
    cmd_mask      = 32'h3;
    step("r6c2", 64'h1, 0, 0, 0, 0);
    step("r6c3", 64'h1, 1, 0, 0, 0);
    RST = 1'b1;
    abort = 1'b1;
    step("r6rs", 64'h0, 0, 0, 1, 0);
    RST = 1'b0;
    abort = 1'b0;
    cmd_comparand = 32'h2;
    step("r6a1", 64'h6, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    step("r6a2", 64'h6, 0, 0, 0, 0);
    step("r6a3", 64'h6, 1, 0, 0, 0);
    step("r6a4", 64'h0, 0, 1, 0, 0);
    step("r6a5", 64'h0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
